life_step_engine: RTL and testbench

Generation-update engine that drives port 1 (read-with-neighbours / write) of the field RAM. On a start pulse it scans the field row-major, evaluates the Conway B3/S23 rule for every cell from the RAM's combinational cell and neighbour outputs, and writes next-generation states back in place. In-place writes are deferred one row through a two-row result buffer so no cell is overwritten before all its neighbours have read it. Port 2 stays free for the display path.

---
 rtl/life_step_engine.sv | 156 +++++++++++++++
 tb/tb_life_step_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_step_engine.sv
// Conway B3/S23 generation engine on port 1 of the field RAM: scans the field
// row-major and writes each row back one row late through a two-row buffer.
module life_step_engine #(
  parameter int FIELD_W   = 8,
  parameter int FIELD_H   = 6,
  parameter int GEN_CNT_W = 16,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = (FIELD_H > 1) ? $clog2(FIELD_H) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_cell_state,
  input  logic [7:0]            i_nbrs,
  output logic [X_ADR_SIZE-1:0] o_x_adr,
  output logic [Y_ADR_SIZE-1:0] o_y_adr,
  output logic                  o_w_en,
  output logic                  o_new_cell_state,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [GEN_CNT_W-1:0]  o_gen_cnt,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {IDLE, CALC, WRITE, WLAST, DONE} state_t;

  localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

  state_t                 state, next_state;
  logic [X_ADR_SIZE-1:0]  x_q;
  logic [Y_ADR_SIZE-1:0]  y_q;
  logic [FIELD_W-1:0]     cur_buf, prev_buf, cur_next;
  logic [GEN_CNT_W-1:0]   gen_cnt;
  logic [3:0]             n_alive;
  logic                   next_cell, x_last, y_last, y_first;

  assign x_last  = (x_q == X_LAST);
  assign y_last  = (y_q == Y_LAST);
  assign y_first = (y_q == '0);

  always_comb begin
    n_alive = '0;
    for (int i = 0; i < 8; i++) n_alive = n_alive + {3'b000, i_nbrs[i]};
    next_cell = (n_alive == 4'd3) | (i_cell_state & (n_alive == 4'd2));
  end

  // Current row including the cell being evaluated this cycle.
  always_comb begin
    cur_next      = cur_buf;
    cur_next[x_q] = next_cell;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // i_start is a single-cycle request with no ready: it is consumed only in
  // IDLE and silently dropped in every other state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (i_start) next_state = CALC;
      CALC:  if (x_last) begin
               if (y_first) next_state = (FIELD_H == 1) ? WLAST : CALC;
               else         next_state = WRITE;
             end
      WRITE: if (x_last) next_state = y_last ? WLAST : CALC;
      WLAST: if (x_last) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      cur_buf  <= '0;
      prev_buf <= '0;
      gen_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          x_q <= '0;
          y_q <= '0;
        end
        CALC: begin
          cur_buf[x_q] <= next_cell;
          if (x_last) begin
            x_q <= '0;
            if (y_first) begin
              prev_buf <= cur_next;
              if (FIELD_H > 1) y_q <= Y_ADR_SIZE'(1);
            end
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        WRITE: begin
          if (x_last) begin
            x_q      <= '0;
            prev_buf <= cur_buf;
            if (!y_last) y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        WLAST: begin
          if (x_last) x_q <= '0;
          else        x_q <= x_q + 1'b1;
        end
        DONE: gen_cnt <= gen_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // WRITE lags the scan by one row, so it addresses the row above the counter.
  always_comb begin
    o_x_adr          = '0;
    o_y_adr          = '0;
    o_w_en           = 1'b0;
    o_new_cell_state = 1'b0;
    o_busy           = 1'b0;
    o_done           = 1'b0;
    case (state)
      CALC: begin
        o_x_adr = x_q;
        o_y_adr = y_q;
        o_busy  = 1'b1;
      end
      WRITE: begin
        o_x_adr          = x_q;
        o_y_adr          = y_q - Y_ADR_SIZE'(1);
        o_w_en           = 1'b1;
        o_new_cell_state = prev_buf[x_q];
        o_busy           = 1'b1;
      end
      WLAST: begin
        o_x_adr          = x_q;
        o_y_adr          = Y_LAST;
        o_w_en           = 1'b1;
        o_new_cell_state = prev_buf[x_q];
        o_busy           = 1'b1;
      end
      DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_gen_cnt = gen_cnt;
  assign o_state   = state;

endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine: behavioural field RAM, reference Life model
// feeding an expected-write queue, and directed pattern/timing/reset cases.
module tb_life_step_engine;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start = 1'b0;
  logic          i_cell_state;
  logic [7:0]    i_nbrs;
  logic [2:0]    o_x_adr;
  logic [2:0]    o_y_adr;
  logic          o_w_en, o_new_cell_state, o_busy, o_done;
  logic [GW-1:0] o_gen_cnt;
  logic [2:0]    o_state;

  logic [W-1:0]  field     [H];
  logic [W-1:0]  bd_field  [H];
  logic [W-1:0]  exp_field [H];
  logic [W-1:0]  old_field [H];
  logic          bd_load = 1'b0;
  logic [6:0]    exp_q[$];
  logic [6:0]    mon_e;
  logic [GW-1:0] exp_gen = '0;
  int            n_checks = 0;
  int            n_errors = 0;
  int            oob_cnt = 0;

  life_step_engine #(.FIELD_W(W), .FIELD_H(H), .GEN_CNT_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_cell_state(i_cell_state), .i_nbrs(i_nbrs),
    .o_x_adr(o_x_adr), .o_y_adr(o_y_adr), .o_w_en(o_w_en),
    .o_new_cell_state(o_new_cell_state), .o_busy(o_busy), .o_done(o_done),
    .o_gen_cnt(o_gen_cnt), .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- field RAM model ----------------
  always @(posedge clk) begin
    if (bd_load) begin
      for (int r = 0; r < H; r++) field[r] <= bd_field[r];
    end else if (o_w_en && int'(o_y_adr) < H) begin
      field[o_y_adr][o_x_adr] <= o_new_cell_state;
    end
  end

  always_comb begin
    int k, nx, ny;
    i_cell_state = 1'b0;
    i_nbrs       = '0;
    k            = 0;
    if (int'(o_y_adr) < H) i_cell_state = field[o_y_adr][o_x_adr];
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) begin
          nx = int'(o_x_adr) + dx;
          ny = int'(o_y_adr) + dy;
          if (nx >= 0 && nx < W && ny >= 0 && ny < H) i_nbrs[k] = field[ny][nx];
          k = k + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_field(input string tag);
    for (int r = 0; r < H; r++)
      check($sformatf("%s_row%0d", tag, r), 32'(field[r]), 32'(exp_field[r]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"},    32'(o_x_adr), 0);
    check({tag, "_y"},    32'(o_y_adr), 0);
    check({tag, "_wen"},  32'(o_w_en), 0);
    check({tag, "_data"}, 32'(o_new_cell_state), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_gen"},  32'(o_gen_cnt), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_busy && int'(o_y_adr) >= H) oob_cnt++;
      if (o_w_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("write", {25'b0, o_y_adr, o_x_adr, o_new_cell_state}, {25'b0, mon_e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_bd();
    for (int r = 0; r < H; r++) bd_field[r] = '0;
  endtask

  task automatic set_bd(input int x, input int y);
    bd_field[y][x] = 1'b1;
  endtask

  task automatic load_field();
    @(negedge clk);
    bd_load = 1'b1;
    @(negedge clk);
    bd_load = 1'b0;
    for (int r = 0; r < H; r++) exp_field[r] = bd_field[r];
  endtask

  // Reference generation step; queues the writes in row-major order.
  task automatic push_gen();
    logic [W-1:0] nxt [H];
    int n;
    logic alive;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
              n += int'(exp_field[y + dy][x + dx]);
        alive = (n == 3) || (exp_field[y][x] && n == 2);
        nxt[y][x] = alive;
        exp_q.push_back({3'(y), 3'(x), alive});
      end
    end
    for (int r = 0; r < H; r++) exp_field[r] = nxt[r];
    exp_gen++;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    @(negedge clk);
    check({tag, "_gen_cnt"}, 32'(o_gen_cnt), 32'(exp_gen));
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check_field(tag);
  endtask

  task automatic run_gen(input string tag);
    push_gen();
    pulse_start();
    wait_done(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Blinker oscillates with period 2
    clear_bd(); set_bd(2, 2); set_bd(3, 2); set_bd(4, 2);
    load_field();
    run_gen("blinker1");
    check("blinker_vert_r1", 32'(field[1]), 32'h08);
    check("blinker_vert_r2", 32'(field[2]), 32'h08);
    check("blinker_vert_r3", 32'(field[3]), 32'h08);
    run_gen("blinker2");
    check("blinker_horiz_r2", 32'(field[2]), 32'h1C);
    check("blinker_gen_cnt", 32'(o_gen_cnt), 2);

    // Busy/done timing, ignored starts, start accepted back in IDLE
    push_gen();
    push_gen();
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 99; k++) begin
      @(negedge clk);
      if (k == 1 || k == 11 || k == 99) i_start = 1'b0;
      if (k == 10 || k == 97) i_start = 1'b1;
      if (k <= 98) begin
        check($sformatf("timing_busy_c%0d", k), 32'(o_busy), 32'(k <= 96));
        check($sformatf("timing_done_c%0d", k), 32'(o_done), 32'(k == 97));
      end else begin
        check("timing_restart_busy", 32'(o_busy), 1);
      end
    end
    wait_done("timing");

    // Block still life in the corner
    clear_bd(); set_bd(0, 0); set_bd(1, 0); set_bd(0, 1); set_bd(1, 1);
    load_field();
    oob_cnt = 0;
    for (int g = 0; g < 3; g++) run_gen($sformatf("block%0d", g));
    check("block_r0", 32'(field[0]), 32'h03);
    check("block_r1", 32'(field[1]), 32'h03);
    check("block_oob", oob_cnt, 0);

    // Glider moves (+1,+1) every 4 generations
    clear_bd(); set_bd(1, 0); set_bd(2, 1); set_bd(0, 2); set_bd(1, 2); set_bd(2, 2);
    load_field();
    for (int g = 0; g < 4; g++) run_gen($sformatf("glider%0d", g));
    check("glider_r0", 32'(field[0]), 32'h00);
    check("glider_r1", 32'(field[1]), 32'h04);
    check("glider_r2", 32'(field[2]), 32'h08);
    check("glider_r3", 32'(field[3]), 32'h0E);

    // Empty field stays empty
    clear_bd();
    load_field();
    run_gen("empty");
    check("empty_r3", 32'(field[3]), 32'h00);

    // Full field: only corners survive
    for (int r = 0; r < H; r++) bd_field[r] = '1;
    load_field();
    run_gen("full");
    check("full_r0", 32'(field[0]), 32'h81);
    check("full_r2", 32'(field[2]), 32'h00);
    check("full_r5", 32'(field[5]), 32'h81);

    // Reset during the write-back of row 2
    for (int r = 0; r < H; r++) bd_field[r] = W'($urandom_range(0, 255));
    load_field();
    for (int r = 0; r < H; r++) old_field[r] = exp_field[r];
    push_gen();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (o_w_en && o_y_adr == 3'd2) found = 1'b1;
    end
    check("midrun_row2_write_seen", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    for (int r = 2; r < H; r++) exp_field[r] = old_field[r];
    exp_gen = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_field("after_reset");
    run_gen("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
